dmem_access_unit: RTL and testbench

DMEM_ACCESS_UNIT -- requirements
Module: dmem_access_unit

---
 rtl/dmem_access_unit_if.sv | 21 ++
 rtl/dmem_access_unit.sv | 156 +++++++++++++++
 tb/tb_dmem_access_unit.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/dmem_access_unit_if.sv
// Data-memory bus between the access unit (master) and the memory system (slave).
// Request fields stay stable while bus_req is high; bus_ready completes the transfer.
interface dmem_access_unit_if;
   logic        bus_req;
   logic        bus_we;
   logic [63:0] bus_addr;
   logic [63:0] bus_wdata;
   logic [7:0]  bus_wstrb;
   logic        bus_ready;
   logic [63:0] bus_rdata;

   modport master (
      output bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb,
      input  bus_ready, bus_rdata
   );

   modport slave (
      input  bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb,
      output bus_ready, bus_rdata
   );
endinterface

// File: rtl/dmem_access_unit.sv
// Load/store unit: validates core requests, runs one aligned bus transfer per access,
// lane-shifts store data and sign/zero-extends load data, with a bus timeout abort.
module dmem_access_unit #(
   parameter int unsigned BUS_TIMEOUT = 1023
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       data_mem_read_enable_i,
   input  logic                       data_mem_write_enable_i,
   input  logic [2:0]                 funct3_i,
   input  logic [63:0]                address_i,
   input  logic [63:0]                write_data_i,
   output logic [63:0]                read_data_o,
   output logic                       stall_o,
   output logic                       access_fault_o,
   output logic                       bus_error_o,
   dmem_access_unit_if.master         bus
);

   localparam int unsigned CntW = (BUS_TIMEOUT > 1) ? $clog2(BUS_TIMEOUT) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(BUS_TIMEOUT - 1);

   typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

   state_e            state_q, state_d;
   logic              bus_req_q, bus_req_d;
   logic              bus_we_q, bus_we_d;
   logic [63:0]       bus_addr_q, bus_addr_d;
   logic [63:0]       bus_wdata_q, bus_wdata_d;
   logic [7:0]        bus_wstrb_q, bus_wstrb_d;
   logic [2:0]        funct3_q, funct3_d;
   logic [2:0]        offset_q, offset_d;
   logic [63:0]       read_data_q, read_data_d;
   logic              bus_error_q, bus_error_d;
   logic [CntW-1:0]   cnt_q, cnt_d;

   logic              rd, wr, legal_f3, aligned, req_valid;
   logic [7:0]        size_mask;
   logic [63:0]       rshift, load_ext;

   assign rd = data_mem_read_enable_i;
   assign wr = data_mem_write_enable_i;

   always_comb begin
      legal_f3 = rd ? (funct3_i != 3'd7) : !funct3_i[2];
      unique case (funct3_i[1:0])
         2'd0:    begin aligned = 1'b1;                   size_mask = 8'h01; end
         2'd1:    begin aligned = !address_i[0];          size_mask = 8'h03; end
         2'd2:    begin aligned = (address_i[1:0] == 0);  size_mask = 8'h0F; end
         default: begin aligned = (address_i[2:0] == 0);  size_mask = 8'hFF; end
      endcase
      req_valid = (rd ^ wr) && legal_f3 && aligned;
   end

   always_comb begin
      rshift = bus.bus_rdata >> {offset_q, 3'b000};
      case (funct3_q)
         3'd0:    load_ext = {{56{rshift[7]}},  rshift[7:0]};
         3'd1:    load_ext = {{48{rshift[15]}}, rshift[15:0]};
         3'd2:    load_ext = {{32{rshift[31]}}, rshift[31:0]};
         3'd4:    load_ext = {56'd0, rshift[7:0]};
         3'd5:    load_ext = {48'd0, rshift[15:0]};
         3'd6:    load_ext = {32'd0, rshift[31:0]};
         default: load_ext = rshift;
      endcase
   end

   always_comb begin
      state_d        = state_q;
      bus_req_d      = bus_req_q;
      bus_we_d       = bus_we_q;
      bus_addr_d     = bus_addr_q;
      bus_wdata_d    = bus_wdata_q;
      bus_wstrb_d    = bus_wstrb_q;
      funct3_d       = funct3_q;
      offset_d       = offset_q;
      read_data_d    = read_data_q;
      bus_error_d    = 1'b0;
      cnt_d          = cnt_q;
      stall_o        = 1'b0;
      access_fault_o = 1'b0;
      case (state_q)
         StIdle: begin
            if (req_valid) begin
               stall_o     = 1'b1;
               state_d     = StAccess;
               bus_req_d   = 1'b1;
               bus_we_d    = wr;
               bus_addr_d  = {address_i[63:3], 3'b000};
               bus_wdata_d = write_data_i << {address_i[2:0], 3'b000};
               bus_wstrb_d = wr ? (size_mask << address_i[2:0]) : 8'h00;
               funct3_d    = funct3_i;
               offset_d    = address_i[2:0];
               cnt_d       = '0;
            end else if (rd || wr) begin
               access_fault_o = 1'b1;
            end
         end
         StAccess: begin
            stall_o = 1'b1;
            if (bus.bus_ready) begin
               state_d   = StDone;
               bus_req_d = 1'b0;
               if (!bus_we_q) read_data_d = load_ext;
            end else if (cnt_q == CntLast) begin
               // Abort: the store is dropped, a load returns zero.
               state_d     = StDone;
               bus_req_d   = 1'b0;
               bus_error_d = 1'b1;
               if (!bus_we_q) read_data_d = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         bus_req_q   <= 1'b0;
         bus_we_q    <= 1'b0;
         bus_addr_q  <= '0;
         bus_wdata_q <= '0;
         bus_wstrb_q <= '0;
         funct3_q    <= '0;
         offset_q    <= '0;
         read_data_q <= '0;
         bus_error_q <= 1'b0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         bus_req_q   <= bus_req_d;
         bus_we_q    <= bus_we_d;
         bus_addr_q  <= bus_addr_d;
         bus_wdata_q <= bus_wdata_d;
         bus_wstrb_q <= bus_wstrb_d;
         funct3_q    <= funct3_d;
         offset_q    <= offset_d;
         read_data_q <= read_data_d;
         bus_error_q <= bus_error_d;
         cnt_q       <= cnt_d;
      end
   end

   assign bus.bus_req   = bus_req_q;
   assign bus.bus_we    = bus_we_q;
   assign bus.bus_addr  = bus_addr_q;
   assign bus.bus_wdata = bus_wdata_q;
   assign bus.bus_wstrb = bus_wstrb_q;
   assign read_data_o   = read_data_q;
   assign bus_error_o   = bus_error_q;

endmodule

// File: tb/tb_dmem_access_unit.sv
// Directed bench for dmem_access_unit: inputs change 1 ns after the rising edge,
// outputs are checked on the falling edge.
module tb_dmem_access_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        rd_en, wr_en;
   logic [2:0]  f3;
   logic [63:0] addr, wdata;
   logic [63:0] read_data;
   logic        stall, fault, bus_error;
   int          checks = 0;
   int          errors = 0;

   dmem_access_unit_if bus_if ();

   dmem_access_unit #(.BUS_TIMEOUT(4)) dut (
      .clk                     (clk),
      .rst                     (rst),
      .data_mem_read_enable_i  (rd_en),
      .data_mem_write_enable_i (wr_en),
      .funct3_i                (f3),
      .address_i               (addr),
      .write_data_i            (wdata),
      .read_data_o             (read_data),
      .stall_o                 (stall),
      .access_fault_o          (fault),
      .bus_error_o             (bus_error),
      .bus                     (bus_if)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic r, input logic w, input logic [2:0] f,
                        input logic [63:0] a, input logic [63:0] d);
      rd_en = r; wr_en = w; f3 = f; addr = a; wdata = d;
   endtask

   task automatic test_reset();
      rst = 1'b1; issue(0, 0, 0, 0, 0);
      bus_if.bus_ready = 1'b0; bus_if.bus_rdata = '0;
      #2;
      checks++; if (bus_if.bus_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b want 0", bus_if.bus_req); end
      checks++; if (read_data !== 64'd0) begin errors++; $display("FAIL rst_rdata: got %h want 0", read_data); end
      checks++; if ({bus_if.bus_we, bus_if.bus_wstrb, bus_error} !== 10'd0) begin errors++; $display("FAIL rst_ctl: got %h want 0", {bus_if.bus_we, bus_if.bus_wstrb, bus_error}); end
      checks++; if ((bus_if.bus_addr | bus_if.bus_wdata) !== 64'd0) begin errors++; $display("FAIL rst_bus: got %h want 0", bus_if.bus_addr | bus_if.bus_wdata); end
      step(); step();
      rst = 1'b0;
      @(negedge clk);
      checks++; if ({stall, fault} !== 2'b00) begin errors++; $display("FAIL rst_idle: got %b want 00", {stall, fault}); end
      step();
   endtask

   task automatic test_ld();
      issue(1, 0, 3'd3, 64'h1000, 0);
      @(negedge clk);
      checks++; if ({stall, bus_if.bus_req} !== 2'b10) begin errors++; $display("FAIL ld_c0: got %b want 10", {stall, bus_if.bus_req}); end
      step();
      bus_if.bus_ready = 1'b1; bus_if.bus_rdata = 64'h1122334455667788;
      @(negedge clk);
      checks++; if ({stall, bus_if.bus_req, bus_if.bus_we} !== 3'b110) begin errors++; $display("FAIL ld_c1: got %b want 110", {stall, bus_if.bus_req, bus_if.bus_we}); end
      checks++; if (bus_if.bus_addr !== 64'h1000) begin errors++; $display("FAIL ld_addr: got %h want 1000", bus_if.bus_addr); end
      checks++; if (bus_if.bus_wstrb !== 8'h00) begin errors++; $display("FAIL ld_wstrb: got %h want 00", bus_if.bus_wstrb); end
      step();
      bus_if.bus_ready = 1'b0;
      @(negedge clk);
      checks++; if ({stall, bus_if.bus_req} !== 2'b00) begin errors++; $display("FAIL ld_c2: got %b want 00", {stall, bus_if.bus_req}); end
      checks++; if (read_data !== 64'h1122334455667788) begin errors++; $display("FAIL ld_data: got %h want 1122334455667788", read_data); end
      issue(0, 0, 0, 0, 0);
      step();
   endtask

   task automatic test_lb_lbu();
      logic [2:0]  fs [2] = '{3'd0, 3'd4};
      logic [63:0] exp [2] = '{64'hFFFFFFFFFFFFFF80, 64'h80};
      for (int i = 0; i < 2; i++) begin
         issue(1, 0, fs[i], 64'h1003, 0);
         step();
         bus_if.bus_ready = 1'b1; bus_if.bus_rdata = 64'h00000000_80000000;
         @(negedge clk);
         checks++; if (bus_if.bus_addr !== 64'h1000) begin errors++; $display("FAIL lb%0d_addr: got %h want 1000", i, bus_if.bus_addr); end
         step();
         bus_if.bus_ready = 1'b0;
         @(negedge clk);
         checks++; if (read_data !== exp[i]) begin errors++; $display("FAIL lb%0d_data: got %h want %h", i, read_data, exp[i]); end
         issue(0, 0, 0, 0, 0);
         step();
      end
   endtask

   task automatic test_sh_wait();
      issue(0, 1, 3'd1, 64'h1006, 64'hABCD);
      @(negedge clk);
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL sh_c0_stall: got %b want 1", stall); end
      for (int c = 1; c <= 4; c++) begin
         step();
         bus_if.bus_ready = (c == 4); bus_if.bus_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
         @(negedge clk);
         checks++; if ({stall, bus_if.bus_req, bus_if.bus_we, bus_if.bus_wstrb} !== 11'b111_1100_0000) begin errors++; $display("FAIL sh_c%0d_ctl: got %b want 11111000000", c, {stall, bus_if.bus_req, bus_if.bus_we, bus_if.bus_wstrb}); end
         checks++; if (bus_if.bus_wdata !== 64'hABCD000000000000) begin errors++; $display("FAIL sh_c%0d_wdata: got %h want abcd000000000000", c, bus_if.bus_wdata); end
      end
      step();
      bus_if.bus_ready = 1'b0;
      @(negedge clk);
      checks++; if ({stall, bus_if.bus_req, bus_error} !== 3'b000) begin errors++; $display("FAIL sh_c5: got %b want 000", {stall, bus_if.bus_req, bus_error}); end
      checks++; if (read_data !== 64'h80) begin errors++; $display("FAIL sh_rdata_kept: got %h want 80", read_data); end
      issue(0, 0, 0, 0, 0);
      step();
   endtask

   task automatic test_faults();
      logic        rs [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
      logic        ws [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
      logic [2:0]  fs [4] = '{3'd2, 3'd3, 3'd4, 3'd7};
      logic [63:0] as [4] = '{64'h1002, 64'h1000, 64'h1000, 64'h1000};
      for (int v = 0; v < 4; v++) begin
         issue(rs[v], ws[v], fs[v], as[v], 64'h55);
         for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checks++; if ({fault, stall, bus_if.bus_req} !== 3'b100) begin errors++; $display("FAIL fault%0d_c%0d: got %b want 100", v, c, {fault, stall, bus_if.bus_req}); end
            step();
         end
      end
      issue(0, 0, 0, 0, 0);
      @(negedge clk);
      checks++; if (fault !== 1'b0) begin errors++; $display("FAIL fault_clear: got %b want 0", fault); end
      step();
   endtask

   task automatic test_ready_outside();
      bus_if.bus_ready = 1'b1; bus_if.bus_rdata = 64'h1234;
      step(); step();
      @(negedge clk);
      checks++; if ({read_data, bus_if.bus_req} !== {64'h80, 1'b0}) begin errors++; $display("FAIL idle_ready: got %h/%b want 80/0", read_data, bus_if.bus_req); end
      bus_if.bus_ready = 1'b0;
      step();
   endtask

   task automatic test_timeout();
      issue(1, 0, 3'd3, 64'h2000, 0);
      for (int c = 1; c <= 4; c++) begin
         step();
         @(negedge clk);
         checks++; if ({bus_if.bus_req, stall} !== 2'b11) begin errors++; $display("FAIL to_c%0d: got %b want 11", c, {bus_if.bus_req, stall}); end
      end
      step();
      @(negedge clk);
      checks++; if ({bus_if.bus_req, bus_error, stall} !== 3'b010) begin errors++; $display("FAIL to_abort: got %b want 010", {bus_if.bus_req, bus_error, stall}); end
      checks++; if (read_data !== 64'd0) begin errors++; $display("FAIL to_rdata: got %h want 0", read_data); end
      issue(0, 0, 0, 0, 0);
      step();
      @(negedge clk);
      checks++; if (bus_error !== 1'b0) begin errors++; $display("FAIL to_pulse: got %b want 0", bus_error); end
      step();
   endtask

   task automatic test_back_to_back();
      issue(1, 0, 3'd2, 64'h1004, 0);
      step();
      bus_if.bus_ready = 1'b1; bus_if.bus_rdata = 64'h80000000_00000000;
      step();
      bus_if.bus_ready = 1'b0;
      issue(1, 0, 3'd5, 64'h1002, 0);
      @(negedge clk);
      checks++; if ({stall, bus_if.bus_req} !== 2'b00) begin errors++; $display("FAIL b2b_done: got %b want 00", {stall, bus_if.bus_req}); end
      checks++; if (read_data !== 64'hFFFFFFFF80000000) begin errors++; $display("FAIL b2b_lw: got %h want ffffffff80000000", read_data); end
      step();
      @(negedge clk);
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL b2b_reissue: got %b want 1", stall); end
      step();
      bus_if.bus_ready = 1'b1; bus_if.bus_rdata = 64'h00000000_F00D0000;
      step();
      bus_if.bus_ready = 1'b0;
      @(negedge clk);
      checks++; if (read_data !== 64'hF00D) begin errors++; $display("FAIL b2b_lhu: got %h want f00d", read_data); end
      issue(0, 0, 0, 0, 0);
      step();
   endtask

   task automatic test_reset_mid();
      issue(1, 0, 3'd3, 64'h3000, 0);
      step();
      step();
      @(negedge clk);
      checks++; if (bus_if.bus_req !== 1'b1) begin errors++; $display("FAIL rm_busy: got %b want 1", bus_if.bus_req); end
      #1;
      rst = 1'b1; issue(0, 0, 0, 0, 0); bus_if.bus_ready = 1'b1; bus_if.bus_rdata = 64'hFFFF;
      #1;
      checks++; if ({bus_if.bus_req, stall, bus_error} !== 3'b000) begin errors++; $display("FAIL rm_drop: got %b want 000", {bus_if.bus_req, stall, bus_error}); end
      checks++; if (read_data !== 64'd0) begin errors++; $display("FAIL rm_rdata: got %h want 0", read_data); end
      step();
      rst = 1'b0; bus_if.bus_ready = 1'b0;
      step();
      @(negedge clk);
      checks++; if ({bus_if.bus_req, stall, bus_error, read_data} !== 67'd0) begin errors++; $display("FAIL rm_idle: got %h want 0", {bus_if.bus_req, stall, bus_error, read_data}); end
   endtask

   initial begin
      test_reset();
      test_ld();
      test_lb_lbu();
      test_sh_wait();
      test_faults();
      test_ready_outside();
      test_timeout();
      test_back_to_back();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
